// File: rtl/bubble_output_sequencer.sv
// Bubble output sequencer: prefetches page/bootloop bytes from the shared buffer
// RAM into a two-slot buffer and shifts them LSB-first onto BDOUT at each strobe.
module bubble_output_sequencer #(
  parameter int BOOT_BYTES  = 514,
  parameter int PAGE_BYTES  = 73,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic [2:0]  ACCTYPE,
  input  logic [12:0] BOUTCYCLENUM,
  input  logic        nBOUTCLKEN,
  input  logic        nNOBUBBLE,
  output logic [10:0] MEM_ADDR,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [7:0]  MEM_WDATA,
  input  logic [7:0]  MEM_RDATA,
  input  logic        MEM_ACK,
  input  logic        HOST_REQ,
  input  logic [10:0] HOST_ADDR,
  input  logic [7:0]  HOST_WDATA,
  output logic        HOST_ACK,
  output logic        BDOUT,
  output logic        UNDERRUN,
  output logic        MEMERR
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [9:0]    BOOT_LAST = 10'(BOOT_BYTES - 1);
  localparam logic [10:0]   PAGE_LIM  = 11'(PAGE_BYTES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t        state;
  logic          active_d;
  logic          discard;
  logic [TW-1:0] tmo;
  logic [9:0]    fptr;

  logic          cur_valid, nxt_valid;
  logic [9:0]    cur_tag, nxt_tag;
  logic [7:0]    cur_byte, nxt_byte;

  logic          active, acc_start, acc_end, bootsel;
  logic          strobe, launch_on, hit_cur, hit_nxt, promote;
  logic          rd_keep, in_range;
  logic [12:0]   next_bit;
  logic [9:0]    start_idx, start_ptr, fptr_inc, bit_idx;
  logic [2:0]    bit_sel;

  // Access edges, pointer arithmetic and slot lookup for the current strobe.
  always_comb begin
    active    = ACCTYPE[1];
    bootsel   = (ACCTYPE == 3'b110);
    acc_start = active & ~active_d;
    acc_end   = ~active & active_d;

    next_bit  = BOUTCYCLENUM + 13'd1;
    start_idx = next_bit[12:3];
    start_ptr = (bootsel && (start_idx > BOOT_LAST)) ? 10'd0 : start_idx;
    fptr_inc  = (bootsel && (fptr == BOOT_LAST)) ? 10'd0 : fptr + 10'd1;
    in_range  = bootsel ? (fptr <= BOOT_LAST) : ({1'b0, fptr} < PAGE_LIM);

    strobe    = ~nBOUTCLKEN;
    bit_idx   = BOUTCYCLENUM[12:3];
    bit_sel   = BOUTCYCLENUM[2:0];
    launch_on = strobe & nNOBUBBLE & active;
    hit_cur   = cur_valid & (cur_tag == bit_idx);
    hit_nxt   = nxt_valid & (nxt_tag == bit_idx);
    promote   = launch_on & ~hit_cur & hit_nxt;

    rd_keep   = (state == RD_WAIT) & MEM_ACK & ~discard & active & ~acc_start;
  end

  // Memory-port FSM: prefetch reads during access, host writes outside it.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= IDLE;
      active_d  <= 1'b0;
      discard   <= 1'b0;
      tmo       <= '0;
      fptr      <= '0;
      MEM_ADDR  <= '0;
      MEM_RD    <= 1'b0;
      MEM_WR    <= 1'b0;
      MEM_WDATA <= '0;
      HOST_ACK  <= 1'b0;
      MEMERR    <= 1'b0;
    end else begin
      active_d <= active;
      HOST_ACK <= 1'b0;

      if (acc_start) begin
        fptr   <= start_ptr;
        MEMERR <= 1'b0;
      end
      // A read still in flight across an access boundary belongs to a dead access.
      if ((acc_start || acc_end) && state == RD_WAIT)
        discard <= 1'b1;

      case (state)
        IDLE: begin
          if (active && !acc_start && !nxt_valid && in_range) begin
            MEM_RD   <= 1'b1;
            MEM_ADDR <= {bootsel, fptr};
            tmo      <= '0;
            discard  <= 1'b0;
            state    <= RD_WAIT;
          end else if (!active && HOST_REQ && !HOST_ACK) begin
            MEM_WR    <= 1'b1;
            MEM_ADDR  <= HOST_ADDR;
            MEM_WDATA <= HOST_WDATA;
            tmo       <= '0;
            state     <= WR_WAIT;
          end
        end

        RD_WAIT: begin
          if (MEM_ACK) begin
            MEM_RD <= 1'b0;
            state  <= IDLE;
            if (rd_keep)
              fptr <= fptr_inc;
          end else if (tmo == TMO_LAST) begin
            MEM_RD <= 1'b0;
            MEMERR <= 1'b1;
            state  <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        WR_WAIT: begin
          if (MEM_ACK) begin
            MEM_WR   <= 1'b0;
            HOST_ACK <= 1'b1;
            state    <= IDLE;
          end else if (tmo == TMO_LAST) begin
            MEM_WR   <= 1'b0;
            HOST_ACK <= 1'b1;
            MEMERR   <= 1'b1;
            state    <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Two-slot byte buffer and bit launch; promotion frees next for a same-cycle fill.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
      cur_tag   <= '0;
      nxt_tag   <= '0;
      cur_byte  <= '0;
      nxt_byte  <= '0;
      BDOUT     <= 1'b1;
      UNDERRUN  <= 1'b0;
    end else begin
      if (acc_start || acc_end) begin
        cur_valid <= 1'b0;
        nxt_valid <= 1'b0;
      end else begin
        if (promote) begin
          cur_valid <= 1'b1;
          cur_tag   <= nxt_tag;
          cur_byte  <= nxt_byte;
          nxt_valid <= 1'b0;
        end
        if (rd_keep) begin
          if (!promote && !cur_valid) begin
            cur_valid <= 1'b1;
            cur_tag   <= fptr;
            cur_byte  <= MEM_RDATA;
          end else begin
            nxt_valid <= 1'b1;
            nxt_tag   <= fptr;
            nxt_byte  <= MEM_RDATA;
          end
        end
      end

      if (acc_start)
        UNDERRUN <= 1'b0;

      if (strobe) begin
        if (!launch_on)
          BDOUT <= 1'b1;
        else if (hit_cur)
          BDOUT <= cur_byte[bit_sel];
        else if (hit_nxt)
          BDOUT <= nxt_byte[bit_sel];
        else begin
          BDOUT    <= 1'b1;
          UNDERRUN <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bubble_output_sequencer.sv
// Scoreboard bench: directed stimulus queues expected reads, writes, acks and
// launched bits; a posedge+1 monitor pops and compares as the DUT presents them.
module tb_bubble_output_sequencer;

  logic        MCLK, nRESET;
  logic [2:0]  ACCTYPE;
  logic [12:0] BOUTCYCLENUM;
  logic        nBOUTCLKEN, nNOBUBBLE;
  logic [10:0] MEM_ADDR;
  logic        MEM_RD, MEM_WR;
  logic [7:0]  MEM_WDATA, MEM_RDATA;
  logic        MEM_ACK, HOST_REQ;
  logic [10:0] HOST_ADDR;
  logic [7:0]  HOST_WDATA;
  logic        HOST_ACK, BDOUT, UNDERRUN, MEMERR;

  bubble_output_sequencer dut (
    .MCLK(MCLK), .nRESET(nRESET), .ACCTYPE(ACCTYPE), .BOUTCYCLENUM(BOUTCYCLENUM),
    .nBOUTCLKEN(nBOUTCLKEN), .nNOBUBBLE(nNOBUBBLE), .MEM_ADDR(MEM_ADDR),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .MEM_ACK(MEM_ACK), .HOST_REQ(HOST_REQ), .HOST_ADDR(HOST_ADDR),
    .HOST_WDATA(HOST_WDATA), .HOST_ACK(HOST_ACK), .BDOUT(BDOUT),
    .UNDERRUN(UNDERRUN), .MEMERR(MEMERR)
  );

  typedef struct { logic [10:0] addr; int len; } rd_t;
  typedef struct { logic [10:0] addr; logic [7:0] data; int len; } wr_t;

  rd_t        rd_q[$];
  wr_t        wr_q[$];
  logic [1:0] bd_q[$];
  int         ack_pending = 0;

  int check_count = 0;
  int pass_count  = 0;

  logic [7:0] mem [0:2047];
  int         ack_delay = 1;
  logic       withhold  = 1'b0;
  int         ack_cnt   = 0;

  logic strobe_seen, rd_prev, wr_prev;
  int   rd_cnt, wr_cnt, rd_exp_len, wr_exp_len;
  rd_t  re;
  wr_t  we;
  logic [1:0] be;

  initial MCLK = 1'b0;
  always #10 MCLK = ~MCLK;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory responder: acks after ack_delay cycles unless withheld.
  always @(negedge MCLK) begin
    if (!nRESET) begin
      MEM_ACK = 1'b0;
      ack_cnt = 0;
    end else if (MEM_ACK) begin
      MEM_ACK = 1'b0;
      ack_cnt = 0;
    end else if ((MEM_RD || MEM_WR) && !withhold) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        MEM_ACK   = 1'b1;
        MEM_RDATA = mem[MEM_ADDR];
        if (MEM_WR) mem[MEM_ADDR] = MEM_WDATA;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // Monitor: compares each presented request, ack and launched bit with the queues.
  always @(posedge MCLK) begin
    strobe_seen = !nBOUTCLKEN && nRESET;
    #1;
    if (!nRESET) begin
      rd_prev = 1'b0;
      wr_prev = 1'b0;
    end else begin
      if (strobe_seen) begin
        check_output("bd_expected", bd_q.size() != 0, 1);
        if (bd_q.size() != 0) begin
          be = bd_q.pop_front();
          check_output("bdout", BDOUT, be[1]);
          check_output("underrun", UNDERRUN, be[0]);
        end
      end
      if (MEM_RD && !rd_prev) begin
        check_output("rd_expected", rd_q.size() != 0, 1);
        rd_exp_len = 0;
        if (rd_q.size() != 0) begin
          re = rd_q.pop_front();
          check_output("rd_addr", MEM_ADDR, re.addr);
          rd_exp_len = re.len;
        end
        rd_cnt = 1;
      end else if (MEM_RD) begin
        rd_cnt++;
      end else if (rd_prev && rd_exp_len != 0) begin
        check_output("rd_len", rd_cnt, rd_exp_len);
      end
      if (MEM_WR && !wr_prev) begin
        check_output("wr_expected", wr_q.size() != 0, 1);
        wr_exp_len = 0;
        if (wr_q.size() != 0) begin
          we = wr_q.pop_front();
          check_output("wr_addr", MEM_ADDR, we.addr);
          check_output("wr_data", MEM_WDATA, we.data);
          wr_exp_len = we.len;
        end
        wr_cnt = 1;
      end else if (MEM_WR) begin
        wr_cnt++;
      end else if (wr_prev && wr_exp_len != 0) begin
        check_output("wr_len", wr_cnt, wr_exp_len);
      end
      if (HOST_ACK) begin
        check_output("host_ack_expected", ack_pending > 0, 1);
        if (ack_pending > 0) ack_pending--;
      end
      rd_prev = MEM_RD;
      wr_prev = MEM_WR;
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic launch(input logic [12:0] bitnum, input logic exp_bd, input logic exp_ur);
    BOUTCYCLENUM = bitnum;
    nBOUTCLKEN   = 1'b0;
    bd_q.push_back({exp_bd, exp_ur});
    @(negedge MCLK);
    nBOUTCLKEN = 1'b1;
  endtask

  task automatic wait_host_ack();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge MCLK);
      if (HOST_ACK) seen = 1;
    end
    HOST_REQ = 1'b0;
    check_output("host_ack_seen", seen, 1);
  endtask

  task automatic apply_stimulus();
    bit err_seen;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h000] = 8'hA5; mem[11'h001] = 8'h3C; mem[11'h002] = 8'h0F;
    mem[11'h005] = 8'h00; mem[11'h006] = 8'hFF;
    mem[11'h601] = 8'h96; mem[11'h400] = 8'h5B; mem[11'h401] = 8'h11;

    ACCTYPE = 3'b000; BOUTCYCLENUM = '0; nBOUTCLKEN = 1'b1; nNOBUBBLE = 1'b1;
    HOST_REQ = 1'b0; HOST_ADDR = '0; HOST_WDATA = '0;
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    nRESET = 1'b0;
    ticks(3);
    check_output("rst_mem_rd", MEM_RD, 0);
    check_output("rst_mem_wr", MEM_WR, 0);
    check_output("rst_mem_addr", MEM_ADDR, 0);
    check_output("rst_mem_wdata", MEM_WDATA, 0);
    check_output("rst_host_ack", HOST_ACK, 0);
    check_output("rst_bdout", BDOUT, 1);
    check_output("rst_underrun", UNDERRUN, 0);
    check_output("rst_memerr", MEMERR, 0);
    nRESET = 1'b1;
    ticks(2);

    $display("[TB] USER access from bit 8191");
    rd_q.push_back('{11'h000, 1});
    rd_q.push_back('{11'h001, 1});
    BOUTCYCLENUM = 13'd8191;
    ACCTYPE = 3'b111;
    ticks(8);
    launch(13'd0, 1, 0); launch(13'd1, 0, 0); launch(13'd2, 1, 0); launch(13'd3, 0, 0);
    launch(13'd4, 0, 0); launch(13'd5, 1, 0); launch(13'd6, 0, 0); launch(13'd7, 1, 0);
    rd_q.push_back('{11'h002, 1});
    launch(13'd8, 0, 0);
    ticks(6);
    ACCTYPE = 3'b000;
    ticks(3);

    $display("[TB] host write outside access");
    ack_delay = 3;
    wr_q.push_back('{11'h123, 8'h5A, 3});
    ack_pending++;
    HOST_ADDR = 11'h123; HOST_WDATA = 8'h5A; HOST_REQ = 1'b1;
    wait_host_ack();
    ticks(3);

    $display("[TB] host request during USER access at byte 73");
    BOUTCYCLENUM = 13'd583;
    ACCTYPE = 3'b111;
    HOST_ADDR = 11'h200; HOST_WDATA = 8'hC3; HOST_REQ = 1'b1;
    ticks(10);
    check_output("wr_blocked", MEM_WR, 0);
    check_output("no_rd_73", MEM_RD, 0);
    ack_delay = 2;
    wr_q.push_back('{11'h200, 8'hC3, 2});
    ack_pending++;
    ACCTYPE = 3'b000;
    wait_host_ack();
    ack_delay = 1;
    ticks(3);

    $display("[TB] BOOT access across the 513 -> 0 wrap");
    rd_q.push_back('{11'h601, 1});
    rd_q.push_back('{11'h400, 1});
    BOUTCYCLENUM = 13'd4103;
    ACCTYPE = 3'b110;
    ticks(8);
    launch(13'd4104, 0, 0); launch(13'd4105, 1, 0); launch(13'd4111, 1, 0);
    rd_q.push_back('{11'h401, 1});
    launch(13'd2, 0, 0);
    ticks(5);
    check_output("boot_no_underrun", UNDERRUN, 0);
    ACCTYPE = 3'b000;
    ticks(3);

    $display("[TB] read ack timeout and retry");
    withhold = 1'b1;
    rd_q.push_back('{11'h005, 255});
    rd_q.push_back('{11'h005, 0});
    BOUTCYCLENUM = 13'd39;
    ACCTYPE = 3'b111;
    err_seen = 0;
    for (int i = 0; i < 400 && !err_seen; i++) begin
      @(negedge MCLK);
      if (MEMERR) err_seen = 1;
    end
    check_output("memerr_set", MEMERR, 1);
    ticks(3);
    check_output("rd_retry_pending", MEM_RD, 1);
    launch(13'd40, 1, 1);
    rd_q.push_back('{11'h006, 1});
    withhold = 1'b0;
    ticks(8);
    ACCTYPE = 3'b000;
    ticks(3);

    $display("[TB] forced no-bubble on valid data");
    rd_q.push_back('{11'h005, 1});
    rd_q.push_back('{11'h006, 1});
    ACCTYPE = 3'b111;
    ticks(8);
    check_output("memerr_cleared", MEMERR, 0);
    check_output("underrun_cleared", UNDERRUN, 0);
    launch(13'd40, 0, 0);
    nNOBUBBLE = 1'b0;
    launch(13'd41, 1, 0);
    nNOBUBBLE = 1'b1;
    launch(13'd42, 0, 0);
    ACCTYPE = 3'b000;
    ticks(3);

    $display("[TB] reset during a pending read");
    withhold = 1'b1;
    rd_q.push_back('{11'h000, 0});
    BOUTCYCLENUM = 13'd8191;
    ACCTYPE = 3'b111;
    ticks(6);
    check_output("rd_pending_before_reset", MEM_RD, 1);
    nRESET = 1'b0;
    #1;
    check_output("async_rst_mem_rd", MEM_RD, 0);
    check_output("async_rst_bdout", BDOUT, 1);
    check_output("async_rst_mem_addr", MEM_ADDR, 0);
    ACCTYPE = 3'b000;
    withhold = 1'b0;
    @(negedge MCLK);
    nRESET = 1'b1;
    ticks(2);
    check_output("post_rst_mem_rd", MEM_RD, 0);
    wr_q.push_back('{11'h055, 8'h77, 1});
    ack_pending++;
    HOST_ADDR = 11'h055; HOST_WDATA = 8'h77; HOST_REQ = 1'b1;
    wait_host_ack();
    ticks(5);

    check_output("rd_q_drained", rd_q.size(), 0);
    check_output("wr_q_drained", wr_q.size(), 0);
    check_output("bd_q_drained", bd_q.size(), 0);
    check_output("acks_drained", ack_pending, 0);
  endtask

  initial begin
    apply_stimulus();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_count, check_count);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bubble_output_sequencer.md
Name: bubble_output_sequencer

Overview:
- Sequences the shared 8-bit page/bootloop buffer RAM behind the timing generator: prefetches bytes ahead of the bubble output bit stream and serialises them onto BDOUT at each output strobe.
- Arbitrates the same RAM between the prefetcher and a host loader port; prefetch always wins, host writes are serviced only outside bubble access.
- Sits between the timing generator (ACCTYPE, BOUTCYCLENUM, nBOUTCLKEN, nNOBUBBLE) and the buffer RAM.

Parameters:
- BOOT_BYTES, 514: bootloop byte count per loop; the fetch pointer wraps to 0 after BOOT_BYTES-1.
- PAGE_BYTES, 73: user page byte count; no fetch is issued at or beyond this index.
- ACK_TIMEOUT, 255: MCLK cycles to wait for MEM_ACK before aborting a read.

Ports:
- MCLK  in  1  master clock, 48 MHz.
- nRESET  in  1  asynchronous active-low reset.
- ACCTYPE  in  3  access type from the timing generator: BOOT=110, USER=111; bit1=0 means no access.
- BOUTCYCLENUM  in  13  output bit index.
- nBOUTCLKEN  in  1  one-MCLK low strobe marking the bit launch point.
- nNOBUBBLE  in  1  0 forces no-bubble output.
- MEM_ADDR  out  11  {bootsel, byte index[9:0]}.
- MEM_RD  out  1  read request, held until MEM_ACK.
- MEM_WR  out  1  write request, held until MEM_ACK.
- MEM_WDATA  out  8  write data.
- MEM_RDATA  in  8  read data, valid when MEM_ACK=1.
- MEM_ACK  in  1  one-cycle completion pulse; latency is variable, at least 1 cycle.
- HOST_REQ  in  1  host write request, level, held until HOST_ACK.
- HOST_ADDR  in  11  host write address.
- HOST_WDATA  in  8  host write data.
- HOST_ACK  out  1  one-cycle pulse when the host write completes.
- BDOUT  out  1  bubble data bit; 1 = no bubble.
- UNDERRUN  out  1  sticky: a bit was needed but its byte was not buffered.
- MEMERR  out  1  sticky: an MEM_ACK timeout occurred.

Behaviour:
- Reset values: MEM_RD=0, MEM_WR=0, MEM_ADDR=0, MEM_WDATA=0, HOST_ACK=0, BDOUT=1, UNDERRUN=0, MEMERR=0. The FSM is in IDLE and both buffer slots are invalid.
- Buffer: two slots, cur and next. Each slot holds a byte, a 10-bit tag and a valid bit. bootsel = (ACCTYPE==110).
- Access start is the cycle in which ACCTYPE[1] goes 0->1 (registered compare):
  - both slots are invalidated;
  - fptr <= ((BOUTCYCLENUM+1) mod 8192)[12:3]; for BOOT, fptr wraps to 0 if it is >= BOOT_BYTES;
  - UNDERRUN and MEMERR are cleared.
- Access end: ACCTYPE[1] goes 1->0. An in-flight read completes, but its data is discarded; both slots are invalidated.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE -> RD_WAIT when ACCTYPE[1]=1, a slot is free (next invalid) and fptr is in range. Drive MEM_RD=1 with MEM_ADDR={bootsel,fptr}.
  - IDLE -> WR_WAIT when ACCTYPE[1]=0 and HOST_REQ=1. Drive MEM_WR=1 with HOST_ADDR and HOST_WDATA latched.
  - If both conditions hold in the same cycle, the read wins. A host request arriving during access stays pending until the access ends.
  - RD_WAIT, on MEM_ACK: the byte is loaded into the free slot with tag=fptr (into cur if cur is invalid, else into next); fptr increments, wrapping for BOOT; MEM_RD drops in the same cycle; return to IDLE.
  - WR_WAIT, on MEM_ACK: MEM_WR drops; HOST_ACK pulses for 1 cycle; return to IDLE.
  - In either wait state, ACK_TIMEOUT cycles without MEM_ACK: drop the request, set MEMERR, return to IDLE. For a read, fptr is not advanced and the read is retried. For a write, HOST_ACK still pulses.
- Bit launch, on each cycle with nBOUTCLKEN=0, with idx=BOUTCYCLENUM[12:3] and b=BOUTCYCLENUM[2:0]:
  - nNOBUBBLE=0 or ACCTYPE[1]=0: BDOUT<=1.
  - else if cur valid and cur.tag==idx: BDOUT<=cur.byte[b] (LSB first).
  - else if next valid and next.tag==idx: BDOUT<=next.byte[b]; next is promoted to cur in the same cycle; next becomes invalid.
  - else: BDOUT<=1 and UNDERRUN<=1.
  - BDOUT holds between strobes. Latency is 1 MCLK from the strobe to BDOUT.
  - Promotion and an MEM_ACK in the same cycle: promotion takes priority, and the acked byte is written into the slot freed by promotion.
- USER: fptr>=PAGE_BYTES stops prefetching. BOOT: continuous wrap 513->0, with tag 0 expected after tag 513.
- Asserting nRESET mid-transaction aborts immediately: all outputs return to their reset values, the request drops and no HOST_ACK is issued.

Test Plan:
- Reset then USER access start with BOUTCYCLENUM=8191: reads issue at addresses 0x000 and 0x001; MEM_ACK returns 0xA5 for byte 0; strobes at bits 0..7 give BDOUT=1,0,1,0,0,1,0,1; a third read at 0x002 follows the promotion.
- BOOT start with BOUTCYCLENUM=4103: first read at {1,513}, second at {1,0}; the strobe for bit 4104 comes from byte 513; no UNDERRUN across the wrap.
- Host write with ACCTYPE=000, MEM_ACK after 3 cycles: MEM_WR is held for 3 cycles and one HOST_ACK pulse follows. HOST_REQ raised during USER: no MEM_WR until ACCTYPE returns to 000.
- MEM_ACK withheld for 255 cycles: MEM_RD drops, MEMERR=1, the read for the same address is reissued, and a strobe for that byte gives BDOUT=1 with UNDERRUN=1.
- nNOBUBBLE=0 on a strobe with valid data: BDOUT=1 and UNDERRUN stays 0. USER byte index 73: no read issued.
- nRESET asserted while RD_WAIT: MEM_RD=0 and BDOUT=1 asynchronously; after release the FSM is IDLE with all slots invalid.
